edgcol_hb_walker: RTL and testbench

- Hardware-block responder for the Xedgcol extension: it is the other end of the core controller's HBStart/HBDone handshake.
- Holds two edge endpoints loaded by Xedgcol LI writes (edgcolWrEna).
- On HBStart, walks the Bresenham line between the endpoints across a square occupancy grid. Reads one grid cell per step from an external 1-bit occupancy RAM.
- Reports collision and cell count on a 32-bit result that the execute-stage mux selects (execSrc=1).

---
 rtl/edgcol_hb_walker.sv | 159 +++++++++++++++
 tb/tb_edgcol_hb_walker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/edgcol_hb_walker.sv
// Xedgcol hardware-block responder: on HBStart walks the Bresenham line between two
// stored endpoints, reading one occupancy cell per step, and reports collision/cell count.
module edgcol_hb_walker #(
    parameter int COORD_WIDTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     edgcolWrEna,
    input  logic                     wrSel,
    input  logic [31:0]              wrData,
    input  logic                     HBStart,
    output logic                     HBDone,
    output logic                     occRe,
    output logic [2*COORD_WIDTH-1:0] occAddr,
    input  logic                     occData,
    output logic [31:0]              hbResult,
    output logic                     busy
);

    localparam int EW = COORD_WIDTH + 3;
    localparam logic [COORD_WIDTH-1:0] ONE_C  = COORD_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   ONE_N  = CNT_WIDTH'(1);
    localparam logic signed [EW-1:0]   ZERO_E = '0;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_READ, S_CHECK, S_DONE} state_t;

    state_t                  r_state;
    logic [COORD_WIDTH-1:0]  r_p0x, r_p0y, r_p1x, r_p1y;
    logic [COORD_WIDTH-1:0]  r_x, r_y, r_x1, r_y1;
    logic signed [EW-1:0]    r_dx, r_dy, r_err;
    logic                    r_sx_pos, r_sy_pos;
    logic [CNT_WIDTH-1:0]    r_cnt;

    logic signed [EW-1:0]    w_x0s, w_y0s, w_x1s, w_y1s;
    logic signed [EW-1:0]    w_dx_init, w_ady_init, w_dy_init;
    logic signed [EW-1:0]    w_e2, w_err_next;
    logic                    w_stepx, w_stepy, w_at_end;
    logic [COORD_WIDTH-1:0]  w_x_next, w_y_next;
    logic [CNT_WIDTH-1:0]    w_cnt_inc;

    function automatic logic [31:0] pack_result(input logic [CNT_WIDTH-1:0] cnt,
                                                input logic col);
        logic [31:0] r;
        r = '0;
        r[16 +: CNT_WIDTH] = cnt;
        r[0] = col;
        return r;
    endfunction

    assign w_x0s = signed'({3'b000, r_p0x});
    assign w_y0s = signed'({3'b000, r_p0y});
    assign w_x1s = signed'({3'b000, r_p1x});
    assign w_y1s = signed'({3'b000, r_p1y});

    assign w_dx_init  = (w_x1s >= w_x0s) ? (w_x1s - w_x0s) : (w_x0s - w_x1s);
    assign w_ady_init = (w_y1s >= w_y0s) ? (w_y1s - w_y0s) : (w_y0s - w_y1s);
    assign w_dy_init  = -w_ady_init;

    // Both step decisions compare against the pre-step error term.
    assign w_e2       = r_err <<< 1;
    assign w_stepx    = (w_e2 >= r_dy);
    assign w_stepy    = (w_e2 <= r_dx);
    assign w_err_next = r_err + (w_stepx ? r_dy : ZERO_E) + (w_stepy ? r_dx : ZERO_E);
    assign w_x_next   = !w_stepx ? r_x : (r_sx_pos ? r_x + ONE_C : r_x - ONE_C);
    assign w_y_next   = !w_stepy ? r_y : (r_sy_pos ? r_y + ONE_C : r_y - ONE_C);
    assign w_at_end   = (r_x == r_x1) && (r_y == r_y1);
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + ONE_N;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p0x <= '0;
            r_p0y <= '0;
            r_p1x <= '0;
            r_p1y <= '0;
        end else if (edgcolWrEna) begin
            if (wrSel) begin
                r_p1x <= wrData[COORD_WIDTH-1:0];
                r_p1y <= wrData[16 +: COORD_WIDTH];
            end else begin
                r_p0x <= wrData[COORD_WIDTH-1:0];
                r_p0y <= wrData[16 +: COORD_WIDTH];
            end
        end
    end

    // Walk datapath: working copies taken in INIT so endpoint writes cannot disturb a walk.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_x      <= r_p0x;
            r_y      <= r_p0y;
            r_x1     <= r_p1x;
            r_y1     <= r_p1y;
            r_dx     <= w_dx_init;
            r_dy     <= w_dy_init;
            r_err    <= w_dx_init + w_dy_init;
            r_sx_pos <= (r_p0x < r_p1x);
            r_sy_pos <= (r_p0y < r_p1y);
        end else if (r_state == S_CHECK && !occData && !w_at_end) begin
            r_x   <= w_x_next;
            r_y   <= w_y_next;
            r_err <= w_err_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            HBDone   <= 1'b0;
            occRe    <= 1'b0;
            occAddr  <= '0;
            hbResult <= '0;
            busy     <= 1'b0;
        end else begin
            HBDone <= 1'b0;
            occRe  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (HBStart) begin
                        r_state <= S_INIT;
                        busy    <= 1'b1;
                    end
                end
                S_INIT: begin
                    r_cnt    <= '0;
                    hbResult <= '0;
                    occRe    <= 1'b1;
                    occAddr  <= {r_p0y, r_p0x};
                    r_state  <= S_READ;
                end
                S_READ: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_cnt <= w_cnt_inc;
                    if (occData || w_at_end) begin
                        HBDone   <= 1'b1;
                        hbResult <= pack_result(w_cnt_inc, occData);
                        r_state  <= S_DONE;
                    end else begin
                        occRe   <= 1'b1;
                        occAddr <= {w_y_next, w_x_next};
                        r_state <= S_READ;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edgcol_hb_walker.sv
// Self-checking bench for edgcol_hb_walker: directed table, corner sequences and
// randomized walks checked against a queue-based line model.
module tb_edgcol_hb_walker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        edgcolWrEna = 1'b0;
    logic        wrSel = 1'b0;
    logic [31:0] wrData = '0;
    logic        HBStart = 1'b0;
    logic        HBDone;
    logic        occRe;
    logic [7:0]  occAddr;
    logic        occData = 1'b0;
    logic [31:0] hbResult;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic occ [0:255];
    int m_x0, m_y0, m_x1, m_y1;

    edgcol_hb_walker #(.COORD_WIDTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .edgcolWrEna(edgcolWrEna), .wrSel(wrSel), .wrData(wrData),
        .HBStart(HBStart), .HBDone(HBDone), .occRe(occRe), .occAddr(occAddr),
        .occData(occData), .hbResult(hbResult), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (occRe) occData <= occ[occAddr];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic clear_grid();
        for (int i = 0; i < 256; i++) occ[i] = 1'b0;
    endtask

    task automatic set_pt(input bit sel, input int x, input int y);
        logic [31:0] d;
        d = $urandom;
        d[3:0]   = x[3:0];
        d[19:16] = y[3:0];
        @(negedge clk);
        edgcolWrEna = 1'b1; wrSel = sel; wrData = d;
        @(negedge clk);
        edgcolWrEna = 1'b0;
        if (sel) begin m_x1 = x; m_y1 = y; end
        else begin m_x0 = x; m_y0 = y; end
    endtask

    // Cells on the line from (x0,y0) to (x1,y1), as {y,x} addresses.
    function automatic void line_cells(input int x0, input int y0, input int x1, input int y1,
                                       output logic [7:0] q[$]);
        int x, y, dx, dy, sx, sy, err, e2;
        q = {};
        x = x0; y = y0;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        for (int guard = 0; guard < 64; guard++) begin
            q.push_back({y[3:0], x[3:0]});
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    task automatic do_walk(input string nm, input int mid, input logic [31:0] mwr,
                           output logic [7:0] got[$], output int done_cyc,
                           output logic [31:0] res);
        logic [7:0]  cells[$];
        int          n, ndone;
        bit          col;
        logic [31:0] exp_res;
        line_cells(m_x0, m_y0, m_x1, m_y1, cells);
        n = cells.size(); col = 1'b0;
        for (int i = 0; i < cells.size(); i++)
            if (occ[cells[i]]) begin n = i + 1; col = 1'b1; break; end
        exp_res = {16'(n), 15'd0, col};
        got = {}; ndone = 0; done_cyc = -1;
        @(negedge clk);
        HBStart = 1'b1;
        for (int c = 1; c <= 2 * n + 6; c++) begin
            @(negedge clk);
            HBStart = 1'b0;
            edgcolWrEna = 1'b0;
            if (occRe) got.push_back(occAddr);
            if (HBDone) begin ndone++; done_cyc = c; end
            if (c == mid) begin
                HBStart = 1'b1; edgcolWrEna = 1'b1; wrSel = 1'b1; wrData = mwr;
                m_x1 = int'(mwr[3:0]); m_y1 = int'(mwr[19:16]);
            end
        end
        res = hbResult;
        chk({nm, " done_pulses"}, ndone, 1);
        chk({nm, " done_cycle"}, done_cyc, 2 * n + 2);
        chk({nm, " reads"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s addr%0d", nm, i), got[i], cells[i]);
        chk({nm, " result"}, res, exp_res);
        chk({nm, " idle"}, busy, 1'b0);
    endtask

    typedef struct {
        int          x0, y0, x1, y1;
        int          occ_addr;
        int          nrd;
        logic [31:0] addrs;
        int          done;
        logic [31:0] res;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0]  got[$];
        int          dc, nd, nr;
        logic [31:0] res, a;

        tbl[0] = '{0, 0, 3, 0, -1, 4, 32'h00010203, 10, 32'h0004_0000};
        tbl[1] = '{0, 0, 3, 0, 8'h02, 3, 32'h00010200, 8, 32'h0003_0001};
        tbl[2] = '{0, 0, 3, 3, -1, 4, 32'h00112233, 10, 32'h0004_0000};
        tbl[3] = '{3, 2, 0, 0, -1, 4, 32'h23121100, 10, 32'h0004_0000};
        tbl[4] = '{5, 7, 5, 7, -1, 1, 32'h75000000, 4, 32'h0001_0000};
        tbl[5] = '{5, 7, 5, 7, 8'h75, 1, 32'h75000000, 4, 32'h0001_0001};

        clear_grid();
        m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
        repeat (2) @(negedge clk);
        chk("reset HBDone", HBDone, 1'b0);
        chk("reset occRe", occRe, 1'b0);
        chk("reset occAddr", occAddr, 8'h00);
        chk("reset hbResult", hbResult, 32'h0);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            clear_grid();
            if (tbl[t].occ_addr >= 0) occ[tbl[t].occ_addr] = 1'b1;
            set_pt(1'b0, tbl[t].x0, tbl[t].y0);
            set_pt(1'b1, tbl[t].x1, tbl[t].y1);
            do_walk($sformatf("vec%0d", t), 0, 32'h0, got, dc, res);
            chk($sformatf("vec%0d tbl_reads", t), got.size(), tbl[t].nrd);
            for (int i = 0; i < tbl[t].nrd && i < got.size(); i++) begin
                a = tbl[t].addrs >> (8 * (3 - i));
                chk($sformatf("vec%0d tbl_addr%0d", t, i), got[i], a[7:0]);
            end
            chk($sformatf("vec%0d tbl_done", t), dc, tbl[t].done);
            chk($sformatf("vec%0d tbl_result", t), res, tbl[t].res);
        end

        // Restart and P1 write during a walk are ignored by that walk.
        clear_grid();
        set_pt(1'b0, 0, 0);
        set_pt(1'b1, 3, 0);
        do_walk("busy", 4, 32'h0003_0000, got, dc, res);
        chk("busy result", res, 32'h0004_0000);
        chk("busy done", dc, 10);
        do_walk("newp1", 0, 32'h0, got, dc, res);
        chk("newp1 addr3", got.size() > 3 ? got[3] : 8'hff, 8'h30);

        // Asynchronous reset in CHECK.
        set_pt(1'b0, 0, 0);
        set_pt(1'b1, 7, 0);
        occ[8'h06] = 1'b1;
        @(negedge clk); HBStart = 1'b1;
        @(negedge clk); HBStart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst HBDone", HBDone, 1'b0);
        chk("rst occRe", occRe, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst hbResult", hbResult, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0;
        nd = 0; nr = 0;
        repeat (20) begin
            @(negedge clk);
            if (HBDone) nd++;
            if (occRe) nr++;
        end
        chk("post_rst no_done", nd, 0);
        chk("post_rst no_reads", nr, 0);
        do_walk("post_rst walk", 0, 32'h0, got, dc, res);

        // Randomized walks against the line model.
        for (int r = 0; r < 25; r++) begin
            int mid;
            clear_grid();
            for (int i = 0; i < 256; i++) occ[i] = ($urandom_range(0, 99) < 8);
            set_pt(1'b0, $urandom_range(0, 15), $urandom_range(0, 15));
            set_pt(1'b1, $urandom_range(0, 15), $urandom_range(0, 15));
            mid = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 6) : 0;
            do_walk($sformatf("rnd%0d", r), mid, $urandom, got, dc, res);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
